// File: rtl/pipe_mio_pkg.sv
// Shared encodings for the memory/I-O pipeline stage: access sizes, I/O window
// offsets, load FSM states and the load lane-select/extension helper.
package pipe_mio_pkg;

  typedef enum logic [1:0] {
    SizeByte    = 2'b00,
    SizeHalf    = 2'b01,
    SizeWord    = 2'b10,
    SizeWordAlt = 2'b11
  } msize_e;

  localparam logic [7:0] OffSw       = 8'h00;
  localparam logic [7:0] OffKey      = 8'h04;
  localparam logic [7:0] OffKeyLatch = 8'h08;
  localparam logic [7:0] OffLed      = 8'h0C;
  localparam logic [7:0] OffHex      = 8'h10;

  typedef enum logic {
    StIdle,
    StLoadWait
  } state_e;

  // Pick the addressed lane out of a 32-bit word and zero/sign-extend it.
  function automatic logic [31:0] load_align(input logic [31:0] word, input msize_e size,
                                             input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SizeByte: return {{24{sgn & b[7]}}, b};
      SizeHalf: return {{16{sgn & h[15]}}, h};
      default:  return word;
    endcase
  endfunction

endpackage

// File: rtl/pipe_mio_if.sv
// Memory-stage bus between the pipeline (master) and the memory/I-O stage (slave).
interface pipe_mio_if;
  logic        mwmem;
  logic        mrmem;
  logic [1:0]  msize;
  logic        msigned;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [31:0] mmo;
  logic        mstall;
  logic        merr;

  modport master (
    output mwmem, mrmem, msize, msigned, malu, mb,
    input  mmo, mstall, merr
  );

  modport slave (
    input  mwmem, mrmem, msize, msigned, malu, mb,
    output mmo, mstall, merr
  );
endinterface

// File: rtl/hex7seg.sv
// Hex digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex7seg (
  input  logic [3:0] value,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    unique case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  end
endmodule

// File: rtl/pipe_mio_stage.sv
// Pipeline memory stage: byte-addressed data RAM with a one-wait-state load path,
// plus a memory-mapped I/O window for switches, keys, LEDs and 7-seg digits.
module pipe_mio_stage import pipe_mio_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned NHEX        = 6,
  parameter int unsigned NLED        = 10,
  parameter int unsigned NSW         = 10,
  parameter int unsigned NKEY        = 3,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
  input  logic                clock,
  input  logic                resetn,
  pipe_mio_if.slave           bus,
  input  logic [NSW-1:0]      sw,
  input  logic [NKEY-1:0]     key,
  output logic [7*NHEX-1:0]   hex,
  output logic [NLED-1:0]     led
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RamBytes = 32'(4 * DEPTH_WORDS);

  state_e          state_q, state_d;
  msize_e          size;
  logic            is_st, is_ld, ram_hit, io_hit, misaligned, bad;
  logic            ram_we, ram_ld, io_we, io_rd, latch_clr;
  logic [AW-1:0]   word_idx;
  logic [5:0]      io_idx;
  logic [3:0]      be;
  logic [31:0]     wdata, rdata_q, io_word;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            merr_q;
  logic [NLED-1:0] led_q;
  logic [3:0]      hex_q [NHEX];
  logic [NKEY-1:0] key_meta_q, key_sync_q, key_prev_q, latch_q, latch_d, key_fall;

  always_comb begin
    size       = msize_e'(bus.msize);
    // Requests are only taken in idle; a simultaneous store and load is a store.
    is_st      = bus.mwmem & (state_q == StIdle);
    is_ld      = bus.mrmem & ~bus.mwmem & (state_q == StIdle);
    ram_hit    = bus.malu < RamBytes;
    io_hit     = bus.malu[31:8] == IO_BASE[31:8];
    misaligned = ((size == SizeHalf) & bus.malu[0]) | (bus.msize[1] & (|bus.malu[1:0]));
    bad        = (is_st | is_ld) & (misaligned | ~(ram_hit | io_hit));
    ram_we     = is_st & ram_hit & ~bad;
    ram_ld     = is_ld & ram_hit & ~bad;
    io_we      = is_st & io_hit & ~ram_hit & ~bad;
    io_rd      = is_ld & io_hit & ~ram_hit & ~bad;
    word_idx   = bus.malu[AW+1:2];
    io_idx     = bus.malu[7:2];
  end

  always_comb begin
    be    = 4'b1111;
    wdata = bus.mb;
    case (size)
      SizeByte: begin
        be    = 4'b0001 << bus.malu[1:0];
        wdata = {4{bus.mb[7:0]}};
      end
      SizeHalf: begin
        be    = bus.malu[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.mb[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata_q <= mem[word_idx];
  end

  always_comb begin
    io_word = '0;
    if (io_idx == OffSw[7:2])       io_word[NSW-1:0]  = sw;
    if (io_idx == OffKey[7:2])      io_word[NKEY-1:0] = ~key_sync_q;
    if (io_idx == OffKeyLatch[7:2]) io_word[NKEY-1:0] = latch_q;
    if (io_idx == OffLed[7:2])      io_word[NLED-1:0] = led_q;
    for (int i = 0; i < NHEX; i++) begin
      if (io_idx == 6'(OffHex[7:2] + i)) io_word[3:0] = hex_q[i];
    end
  end

  // A press landing in the same cycle as the clearing read survives the clear.
  always_comb begin
    key_fall  = key_prev_q & ~key_sync_q;
    latch_clr = io_rd & (io_idx == OffKeyLatch[7:2]) & (bus.malu[1:0] == 2'b00);
    latch_d   = (latch_clr ? '0 : latch_q) | key_fall;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (ram_ld) state_d = StLoadWait;
      StLoadWait: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      merr_q     <= 1'b0;
      led_q      <= '0;
      latch_q    <= '0;
      key_meta_q <= '1;
      key_sync_q <= '1;
      key_prev_q <= '1;
      for (int i = 0; i < NHEX; i++) hex_q[i] <= 4'h0;
    end else begin
      state_q    <= state_d;
      merr_q     <= merr_q | bad;
      latch_q    <= latch_d;
      key_meta_q <= key;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_sync_q;
      if (io_we && io_idx == OffLed[7:2]) led_q <= bus.mb[NLED-1:0];
      for (int i = 0; i < NHEX; i++) begin
        if (io_we && io_idx == 6'(OffHex[7:2] + i)) hex_q[i] <= bus.mb[3:0];
      end
    end
  end

  // Outputs are gated by resetn so reset silences them without waiting for a clock.
  always_comb begin
    bus.mmo    = '0;
    bus.mstall = 1'b0;
    if (resetn) begin
      if (state_q == StLoadWait) begin
        bus.mmo = load_align(rdata_q, size, bus.malu[1:0], bus.msigned);
      end else if (io_rd) begin
        bus.mmo = load_align(io_word, size, bus.malu[1:0], bus.msigned);
      end
      bus.mstall = ram_ld;
    end
  end

  assign bus.merr = merr_q;
  assign led      = led_q;

  for (genvar g = 0; g < NHEX; g++) begin : g_hex
    hex7seg u_hex (
      .value (hex_q[g]),
      .seg   (hex[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_pipe_mio_stage.sv
// Self-checking bench for pipe_mio_stage: directed scenarios plus random traffic
// compared against a byte-level memory and register model.
module tb_pipe_mio_stage;

  localparam int          DEPTH   = 64;
  localparam int          NHEX    = 6;
  localparam int          NLED    = 10;
  localparam int          NSW     = 10;
  localparam int          NKEY    = 3;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;
  localparam logic [31:0] RAMB    = 32'(4 * DEPTH);

  logic                clock;
  logic                resetn;
  logic [NSW-1:0]      sw_drv;
  logic [NKEY-1:0]     key_drv;
  logic [7*NHEX-1:0]   hex;
  logic [NLED-1:0]     led;

  pipe_mio_if bus ();

  pipe_mio_stage #(
    .DEPTH_WORDS (DEPTH),
    .NHEX        (NHEX),
    .NLED        (NLED),
    .NSW         (NSW),
    .NKEY        (NKEY),
    .IO_BASE     (IO_BASE)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus),
    .sw     (sw_drv),
    .key    (key_drv),
    .hex    (hex),
    .led    (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference state
  logic [7:0]      mem_m [DEPTH*4];
  logic [NLED-1:0] led_m;
  logic [3:0]      hex_m [NHEX];
  logic [NKEY-1:0] latch_m;
  logic            merr_m;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [7*NHEX-1:0] hex_exp();
    logic [7*NHEX-1:0] e;
    e = '0;
    for (int i = 0; i < NHEX; i++) e[7*i +: 7] = seg_of(hex_m[i]);
    return e;
  endfunction

  function automatic logic [31:0] io_word_m(input logic [5:0] idx);
    logic [31:0]     v;
    logic [NKEY-1:0] kl;
    v  = '0;
    kl = ~key_drv;
    case (idx)
      6'd0: v = 32'(sw_drv);
      6'd1: v = 32'(kl);
      6'd2: v = 32'(latch_m);
      6'd3: v = 32'(led_m);
      default: if (idx >= 4 && idx < 4 + NHEX) v = 32'(hex_m[idx - 4]);
    endcase
    return v;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] addr);
    logic [31:0] w;
    if (addr < RAMB) return mem_m[addr[7:0]];
    w = io_word_m(addr[7:2]);
    return w[8*addr[1:0] +: 8];
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sg);
    int          n;
    logic [31:0] v;
    n = nbytes(sz);
    v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(byte_at(a + 32'(k))) << (8 * k));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int n;
    n = nbytes(sz);
    if (a < RAMB) begin
      for (int k = 0; k < n; k++) mem_m[a[7:0] + 8'(k)] = d[8*k +: 8];
    end else if (a[7:2] == 6'd3) begin
      led_m = d[NLED-1:0];
    end else if (a[7:2] >= 6'd4 && a[7:2] < 6'(4 + NHEX)) begin
      hex_m[a[7:2] - 6'd4] = d[3:0];
    end
  endtask

  task automatic set_idle();
    bus.mwmem   = 1'b0;
    bus.mrmem   = 1'b0;
    bus.msize   = 2'b10;
    bus.msigned = 1'b0;
    bus.malu    = '0;
    bus.mb      = '0;
  endtask

  task automatic model_reset();
    led_m   = '0;
    latch_m = '0;
    merr_m  = 1'b0;
    for (int i = 0; i < NHEX; i++) hex_m[i] = 4'h0;
  endtask

  // One bus transaction, driven on the falling edge and held until accepted.
  task automatic access(input logic w, input logic r, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
    logic        ram_h, io_h, mis, st, ld, bad;
    logic [31:0] expv;
    @(negedge clock);
    bus.mwmem = w; bus.mrmem = r; bus.msize = sz; bus.msigned = sg; bus.malu = a; bus.mb = d;
    #1;
    ram_h = a < RAMB;
    io_h  = a[31:8] == IO_BASE[31:8];
    mis   = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    st    = w;
    ld    = r && !w;
    bad   = (st || ld) && (mis || !(ram_h || io_h));
    expv  = (ld && !bad) ? model_load(a, sz, sg) : 32'h0;
    if (ld && !bad && ram_h) begin
      check("ld_stall", 64'(bus.mstall), 64'd1);
      @(posedge clock); #1;
      check("ld_wait_stall", 64'(bus.mstall), 64'd0);
      got = bus.mmo;
      check("ram_load", 64'(got), 64'(expv));
      @(posedge clock);
    end else begin
      check("no_stall", 64'(bus.mstall), 64'd0);
      got = bus.mmo;
      check("mmo", 64'(got), 64'(expv));
      @(posedge clock);
    end
    if (bad) merr_m = 1'b1;
    else if (st) model_store(a, sz, d);
    else if (ld && io_h && a[7:0] == 8'h08) latch_m = '0;
    #1;
    set_idle();
    check("merr", 64'(bus.merr), 64'(merr_m));
    check("led", 64'(led), 64'(led_m));
    check("hex", 64'(hex), 64'(hex_exp()));
  endtask

  task automatic init_ram();
    logic [31:0] g;
    for (int i = 0; i < DEPTH; i++) access(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * i), $urandom, g);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, a;
    int          op, cls;
    key_drv = '1;
    sw_drv  = '0;
    set_idle();
    model_reset();
    resetn = 1'b0;
    // Hold a RAM load request during reset: outputs must still read idle.
    bus.mrmem = 1'b1;
    bus.malu  = 32'h10;
    repeat (2) @(posedge clock);
    #1;
    check("rst_mstall", 64'(bus.mstall), 64'd0);
    check("rst_mmo", 64'(bus.mmo), 64'd0);
    check("rst_merr", 64'(bus.merr), 64'd0);
    check("rst_led", 64'(led), 64'd0);
    check("rst_hex", 64'(hex), 64'({NHEX{7'b1000000}}));
    set_idle();
    @(negedge clock);
    resetn = 1'b1;

    init_ram();

    // Sub-word loads from a stored word
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h1234_5678, got);
    access(1'b0, 1'b1, 2'b00, 1'b1, 32'h13, 32'h0, got);
    check("lb_0x13", 64'(got), 64'h12);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0, got);
    check("lhu_0x12", 64'(got), 64'h1234);

    // Byte store and sign-extended byte load
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h80, got);
    access(1'b0, 1'b1, 2'b00, 1'b1, 32'h21, 32'h0, got);
    check("lb_0x21", 64'(got), 64'hFFFF_FF80);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, got);

    // LED and HEX stores
    access(1'b1, 1'b0, 2'b10, 1'b0, IO_BASE + 32'h0C, 32'h3FF, got);
    check("led_3ff", 64'(led), 64'h3FF);
    access(1'b1, 1'b0, 2'b10, 1'b0, IO_BASE + 32'h14, 32'hA, got);
    check("hex1_A", 64'(hex[13:7]), 64'(7'b0001000));
    access(1'b0, 1'b1, 2'b00, 1'b0, IO_BASE + 32'h14, 32'h0, got);

    // Key level and press latch
    @(negedge clock);
    key_drv = 3'b101;
    @(negedge clock);
    access(1'b0, 1'b1, 2'b10, 1'b0, IO_BASE + 32'h04, 32'h0, got);
    check("key_level", 64'(got), 64'h2);
    @(negedge clock);
    key_drv = 3'b111;
    latch_m = latch_m | 3'b010;
    repeat (4) @(negedge clock);
    access(1'b0, 1'b1, 2'b10, 1'b0, IO_BASE + 32'h08, 32'h0, got);
    check("latch_rd1", 64'(got), 64'h2);
    access(1'b0, 1'b1, 2'b10, 1'b0, IO_BASE + 32'h08, 32'h0, got);
    check("latch_rd2", 64'(got), 64'h0);

    // A press whose edge lands in the clearing read's cycle
    @(negedge clock);
    key_drv = 3'b110;
    repeat (4) @(negedge clock);
    key_drv = 3'b111;
    latch_m = 3'b001;
    repeat (4) @(negedge clock);
    key_drv = 3'b110;
    @(negedge clock);
    access(1'b0, 1'b1, 2'b10, 1'b0, IO_BASE + 32'h08, 32'h0, got);
    check("latch_coinc_rd", 64'(got), 64'h1);
    latch_m = 3'b001;
    access(1'b0, 1'b1, 2'b10, 1'b0, IO_BASE + 32'h08, 32'h0, got);
    check("latch_kept", 64'(got), 64'h1);
    key_drv = 3'b111;
    repeat (4) @(negedge clock);

    // Misaligned and unmapped accesses
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h02, 32'h0, got);
    check("misalign_mmo", 64'(got), 64'h0);
    check("misalign_merr", 64'(bus.merr), 64'd1);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, got);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h00, 32'h0, got);
    repeat (3) @(negedge clock);
    check("merr_held", 64'(bus.merr), 64'd1);

    // Reset in the load wait state
    @(negedge clock);
    bus.mrmem = 1'b1; bus.msize = 2'b10; bus.malu = 32'h10;
    @(posedge clock);
    #2;
    check("pre_rst_mmo", 64'(bus.mmo), 64'h1234_5678);
    resetn = 1'b0;
    #1;
    check("rst_ld_mstall", 64'(bus.mstall), 64'd0);
    check("rst_ld_mmo", 64'(bus.mmo), 64'd0);
    check("rst_ld_led", 64'(led), 64'd0);
    check("rst_ld_merr", 64'(bus.merr), 64'd0);
    set_idle();
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    init_ram();

    // Random traffic
    repeat (300) begin
      sw_drv = NSW'($urandom);
      cls    = $urandom_range(0, 9);
      op     = $urandom_range(0, 3);
      if (cls < 6)      a = 32'($urandom_range(0, 255));
      else if (cls < 9) a = IO_BASE | 32'($urandom_range(0, 39));
      else              a = 32'h1000 + 32'($urandom_range(0, 4095));
      access(op == 0 || op == 2, op == 1 || op == 2, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
